// File: rtl/repetition_encoder_tx.sv
// Repetition-coded serial transmitter: LSB-first frame with a start symbol, each symbol held REP cycles.
// Optional even-parity symbol after the data bits when PARITY_EN is defined.
module repetition_encoder_tx #(
  parameter int DATA_W  = 8,
  parameter int REP     = 5,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  localparam int RW = $clog2(REP + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_GAP    = 3'd4
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [RW-1:0]     r_rep;
  logic [BW-1:0]     r_bit;
  logic [GW-1:0]     r_gap;
  logic              r_ser_out;
  logic              r_ser_valid;
  logic              r_frame_done;
`ifdef PARITY_EN
  logic              r_parity;
`endif

  logic              w_rep_last;
  logic              w_bit_last;
  logic              w_gap_last;
  logic              w_final;
  logic [DATA_W-1:0] w_shift_nxt;

  assign w_rep_last  = (r_rep == RW'(REP - 1));
  assign w_bit_last  = (r_bit == BW'(DATA_W - 1));
  assign w_gap_last  = (r_gap == GW'(GAP_CYC - 1));
  assign w_shift_nxt = r_shift >> 1;

  // The last cycle of the final symbol; the frame_done cycle follows it.
`ifdef PARITY_EN
  assign w_final = (r_state == S_PARITY) && w_rep_last;
`else
  assign w_final = (r_state == S_DATA) && w_rep_last && w_bit_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_rep        <= '0;
      r_bit        <= '0;
      r_gap        <= '0;
      r_ser_out    <= 1'b0;
      r_ser_valid  <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      if (w_final) begin
        r_ser_out    <= 1'b0;
        r_ser_valid  <= 1'b0;
        r_frame_done <= 1'b1;
        r_gap        <= '0;
        r_state      <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (data_valid) begin
              r_state     <= S_START;
              r_shift     <= data_in;
              r_rep       <= '0;
              r_ser_out   <= 1'b1;
              r_ser_valid <= 1'b1;
`ifdef PARITY_EN
              r_parity    <= ^data_in;
`endif
            end
          end
          S_START: begin
            if (w_rep_last) begin
              r_state   <= S_DATA;
              r_rep     <= '0;
              r_bit     <= '0;
              r_ser_out <= r_shift[0];
            end else begin
              r_rep <= r_rep + 1'b1;
            end
          end
          S_DATA: begin
            if (!w_rep_last) begin
              r_rep <= r_rep + 1'b1;
            end else if (!w_bit_last) begin
              r_rep     <= '0;
              r_bit     <= r_bit + 1'b1;
              r_shift   <= w_shift_nxt;
              r_ser_out <= w_shift_nxt[0];
            end else begin
`ifdef PARITY_EN
              r_state   <= S_PARITY;
              r_rep     <= '0;
              r_ser_out <= r_parity;
`endif
            end
          end
`ifdef PARITY_EN
          S_PARITY: begin
            r_rep <= r_rep + 1'b1;
          end
`endif
          S_GAP: begin
            if (w_gap_last) begin
              r_state <= S_IDLE;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Handshake: a word transfers on a rising edge where data_valid && data_ready.
  assign data_ready = (r_state == S_IDLE) && !rst;
  assign busy       = (r_state != S_IDLE);
  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_repetition_encoder_tx.sv
// Bench for repetition_encoder_tx: default instance (REP=5, GAP_CYC=2) and a REP=1, GAP_CYC=0 instance.
// Honours PARITY_EN when the build defines it.
module tb_repetition_encoder_tx;
  localparam int DW  = 8;
  localparam int REP = 5;
  localparam int GAP = 2;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = (1 + DW + PAR) * REP;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in, d1_in;
  logic          data_valid, d1_valid;
  logic          data_ready, ser_out, ser_valid, busy, frame_done;
  logic          d1_ready, d1_ser, d1_sv, d1_busy, d1_fd;
  logic [2:0]    dbg_state, d1_dbg;

  int            cyc = 0;
  int            hs_cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [0:0]    exp_q[$];

  repetition_encoder_tx #(.DATA_W(DW), .REP(REP), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  repetition_encoder_tx #(.DATA_W(DW), .REP(1), .GAP_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .data_in(d1_in), .data_valid(d1_valid),
    .data_ready(d1_ready), .ser_out(d1_ser), .ser_valid(d1_sv),
    .busy(d1_busy), .frame_done(d1_fd), .dbg_state(d1_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: start symbol 1, data LSB-first, optional even parity, each repeated rep times.
  task automatic build_expected(input logic [DW-1:0] w, input int rep);
    logic s;
    exp_q.delete();
    for (int sym = 0; sym < 1 + DW + PAR; sym++) begin
      if (sym == 0)       s = 1'b1;
      else if (sym <= DW) s = w[sym-1];
      else                s = ^w;
      for (int r = 0; r < rep; r++) exp_q.push_back(s);
    end
  endtask

  // Driver: present a word until accepted; called just after a rising edge.
  task automatic handshake(input logic [DW-1:0] w, input bit hold);
    int n = 0;
    bit took = 1'b0;
    data_in = w;
    data_valid = 1'b1;
    while (!took && n < 200) begin
      @(negedge clk);
      took = data_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) begin
      n_vec++; n_err++;
      $display("FAIL handshake w=%h: got no acceptance in %0d cycles, required acceptance", w, n);
    end
    hs_cyc = cyc;
    if (!hold) begin
      data_valid = 1'b0;
      data_in = DW'($urandom);
    end
  endtask

  // Checks the frame of w cycle by cycle, then frame_done and the gap cycles.
  task automatic check_frame(input logic [DW-1:0] w, input int poke_at, input int stop_at);
    int n;
    logic e;
    build_expected(w, REP);
    n = (stop_at >= 0) ? stop_at : exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_vec++;
      if ({ser_valid, ser_out, busy, frame_done, data_ready} !== {1'b1, e, 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL frame w=%h sym[%0d]: got v/o/busy/fd/rdy=%b, required %b", w, i,
                 {ser_valid, ser_out, busy, frame_done, data_ready}, {1'b1, e, 1'b1, 1'b0, 1'b0});
      end
      if (poke_at >= 0 && i == poke_at) begin
        data_valid = 1'b1;
        data_in = '0;
      end
      if (poke_at >= 0 && i == poke_at + 1) data_valid = 1'b0;
    end
    if (stop_at < 0) begin
      @(negedge clk);
      n_vec++;
      if ({ser_valid, ser_out, frame_done, busy, data_ready} !== 5'b00110) begin
        n_err++;
        $display("FAIL frame_done w=%h: got v/o/fd/busy/rdy=%b, required 00110", w,
                 {ser_valid, ser_out, frame_done, busy, data_ready});
      end
      for (int g = 1; g < GAP; g++) begin
        @(negedge clk);
        n_vec++;
        if ({ser_valid, ser_out, frame_done, busy, data_ready} !== 5'b00010) begin
          n_err++;
          $display("FAIL gap[%0d] w=%h: got v/o/fd/busy/rdy=%b, required 00010", g, w,
                   {ser_valid, ser_out, frame_done, busy, data_ready});
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid = 1'b0; data_in = '0; d1_valid = 1'b0; d1_in = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ser_out, ser_valid, busy, frame_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got o/v/busy/fd=%b, required 0000", {ser_out, ser_valid, busy, frame_done});
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({data_ready, busy, ser_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: got rdy/busy/v=%b, required 100", {data_ready, busy, ser_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    handshake(8'hA5, 1'b0);
    check_frame(8'hA5, -1, -1);
    @(negedge clk);
    n_vec++;
    if ({data_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL single_idle: got rdy/busy=%b, required 10", {data_ready, busy});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int h1;
    handshake(8'h3C, 1'b1);
    h1 = hs_cyc;
    data_in = 8'hFF;
    check_frame(8'h3C, -1, -1);
    handshake(8'hFF, 1'b0);
    n_vec++;
    if (hs_cyc - h1 !== FLEN + GAP + 1) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d cycles, required %0d", hs_cyc - h1, FLEN + GAP + 1);
    end
    check_frame(8'hFF, -1, -1);
  endtask

  task automatic test_ignore_busy();
    logic [DW-1:0] w;
    int bad = 0;
    w = DW'($urandom_range(1, 255));
    handshake(w, 1'b0);
    check_frame(w, 20, -1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ser_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL ignore_busy: got %0d active cycles after frame, required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    int fd_seen = 0;
    handshake(8'hF0, 1'b0);
    check_frame(8'hF0, -1, 17);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({ser_out, ser_valid, busy, frame_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: got o/v/busy/fd=%b, required 0000", {ser_out, ser_valid, busy, frame_done});
    end
    repeat (3) begin
      @(negedge clk);
      if (frame_done !== 1'b0) fd_seen++;
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b, required 1", data_ready);
    end
    repeat (10) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || ser_valid !== 1'b0) fd_seen++;
    end
    n_vec++;
    if (fd_seen !== 0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d stray cycles, required 0", fd_seen);
    end
    @(posedge clk); #1;
    handshake(8'h81, 1'b0);
    check_frame(8'h81, -1, -1);
  endtask

  task automatic test_parity_words();
    handshake(8'hA5, 1'b0);
    check_frame(8'hA5, -1, -1);
    handshake(8'h07, 1'b0);
    check_frame(8'h07, -1, -1);
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    for (int k = 0; k < 6; k++) begin
      w = DW'($urandom);
      handshake(w, 1'b0);
      check_frame(w, -1, -1);
    end
  endtask

  task automatic test_rep1();
    logic [DW-1:0] w2;
    logic e;
    int n = 0;
    w2 = DW'($urandom);
    d1_in = 8'h5A; d1_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (d1_ready !== 1'b1 && n < 50);
    @(posedge clk); #1;
    d1_in = w2;
    for (int f = 0; f < 2; f++) begin
      build_expected((f == 0) ? 8'h5A : w2, 1);
      for (int i = 0; i < 1 + DW + PAR; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        n_vec++;
        if ({d1_sv, d1_ser, d1_fd} !== {1'b1, e, 1'b0}) begin
          n_err++;
          $display("FAIL rep1 frame%0d sym[%0d]: got v/o/fd=%b, required %b", f, i,
                   {d1_sv, d1_ser, d1_fd}, {1'b1, e, 1'b0});
        end
      end
      @(negedge clk);
      n_vec++;
      if ({d1_sv, d1_ser, d1_fd, d1_ready, d1_busy} !== 5'b00110) begin
        n_err++;
        $display("FAIL rep1 done%0d: got v/o/fd/rdy/busy=%b, required 00110", f,
                 {d1_sv, d1_ser, d1_fd, d1_ready, d1_busy});
      end
      @(posedge clk); #1;
      d1_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_parity_words();
    test_random();
    test_rep1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
